// File: rtl/uart_pkg.sv
// Shared UART definitions for the Tx serializer and the Rx side.
// Holds the transmit state type, the idle line level and the baud divider helper.
package uart_pkg;

  // Transmit frame sequencer states; PARITY is only visited when UART_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Level of an idle UART line (also the stop-bit level)
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles per bit; truncating division, caller must keep the result >= 2
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART serializer.
// Counts 0..BAUD_DIV-1 while enabled, restarts synchronously, and flags the
// last cycle of each bit period with a one-cycle bit_end pulse.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count;
  logic          at_last;

  assign at_last = (count == LAST_COUNT);

  // Baud counter: cleared on restart, wraps at the end of every bit period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      if (at_last) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // A restart cycle never ends a bit, even if the counter happened to sit at its last value
  always_comb begin
    bit_end = enable && !restart && at_last;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Accepts one DATA_WIDTH word per valid/ready handshake and sends it LSB-first
// as start bit, data bits, optional parity bit and STOP_BITS stop bits, each
// BAUD_DIV clock cycles long. SerialDataOut comes straight from a flop.
// Optional feature: define UART_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  SerialDataOut,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned IW       = $clog2(DATA_WIDTH + 1);

  localparam logic [IW-1:0] LAST_DATA_BIT = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP_BIT = IW'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic                  line_q, line_d;
  logic                  done_q, done_d;
  logic                  ready_q;
  logic                  busy_q;
  logic                  accept;
  logic                  bit_end;
  logic                  counting;

`ifdef UART_PARITY_EN
  logic                  parity_q;
`endif

  // The bit timer runs whenever a frame is on the line and is realigned on every accept
  always_comb begin
    counting = (state_q != IDLE);
  end

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .enable (counting),
    .bit_end(bit_end)
  );

  // State, shift register, bit index and line register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      line_q    <= UART_IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      line_q    <= line_d;
      done_q    <= done_d;
    end
  end

  // Handshake flags registered alongside the state so they change on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef UART_PARITY_EN
  // Parity of the accepted word, captured at accept so later tx_data changes cannot disturb it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= (^tx_data) ^ (PARITY_ODD != 0);
    end
  end
`endif

  // Next-state logic: the line value for each bit is decided here one edge ahead,
  // so the line flop switches on exactly the edge that starts the new bit
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    line_d    = line_q;
    done_d    = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        line_d = UART_IDLE_LEVEL;
        if (tx_valid) begin
          accept  = 1'b1;
          shift_d = tx_data;
          state_d = START;
          line_d  = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          line_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_DATA_BIT) begin
            bit_idx_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PARITY;
            line_d    = parity_q;
`else
            state_d   = STOP;
            line_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IW'(1);
            line_d    = shift_d[0];
          end
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_idx_d = '0;
          line_d    = UART_IDLE_LEVEL;
        end
      end
`endif

      STOP: begin
        line_d = UART_IDLE_LEVEL;
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP_BIT) begin
            state_d   = IDLE;
            bit_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        line_d  = UART_IDLE_LEVEL;
      end
    endcase
  end

  // Output drive, all straight from flops
  always_comb begin
    SerialDataOut = line_q;
    tx_ready      = ready_q;
    tx_busy       = busy_q;
    tx_done       = done_q;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (CLK_FREQ=16, BAUD_RATE=1 -> 16 cycles/bit).
// Honours UART_PARITY_EN when defined for the whole build.
module tb_uart_tx_serializer;

  localparam int unsigned CLKF = 16;
  localparam int unsigned BAUD = 1;
  localparam int unsigned BDIV = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned PODD = 0;
`ifdef UART_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned F1 = (1 + DW + P + 1) * BDIV;
  localparam int unsigned F2 = (1 + DW + P + 2) * BDIV;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       line;
  logic       tx_busy;
  logic       tx_done;

  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       line2;
  logic       tx_busy2;
  logic       tx_done2;

  uart_tx_serializer #(
    .CLK_FREQ  (CLKF),
    .BAUD_RATE (BAUD),
    .DATA_WIDTH(DW),
    .STOP_BITS (1),
    .PARITY_ODD(PODD)
  ) u_dut (
    .clk          (clk),
    .reset        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .SerialDataOut(line),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  uart_tx_serializer #(
    .CLK_FREQ  (CLKF),
    .BAUD_RATE (BAUD),
    .DATA_WIDTH(DW),
    .STOP_BITS (2),
    .PARITY_ODD(PODD)
  ) u_dut2 (
    .clk          (clk),
    .reset        (rst_n),
    .tx_data      (tx_data2),
    .tx_valid     (tx_valid2),
    .tx_ready     (tx_ready2),
    .SerialDataOut(line2),
    .tx_busy      (tx_busy2),
    .tx_done      (tx_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding the line level for every remaining cycle of the frame
  bit exp_q[$];
  bit exp_done = 1'b0;
  bit dmy;

  task automatic push_frame(input logic [7:0] d);
    for (int b = 0; b < int'(1 + DW + P + 1); b++) begin
      bit v;
      if (b == 0) v = 1'b0;
      else if (b <= int'(DW)) v = d[b-1];
      else if (P == 1 && b == int'(DW + 1)) v = (($countones(d) % 2) == 1) ^ (PODD != 0);
      else v = 1'b1;
      repeat (BDIV) exp_q.push_back(v);
    end
  endtask

  // Model advances on every rising edge from the same inputs the DUT sees
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else if (exp_q.size() == 0 && tx_valid) begin
      push_frame(tx_data);
      exp_done = 1'b0;
    end else if (exp_q.size() != 0) begin
      dmy = exp_q.pop_front();
      exp_done = (exp_q.size() == 0);
    end else begin
      exp_done = 1'b0;
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        check("rst_line",  32'(line),     1);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy",  32'(tx_busy),  0);
        check("rst_done",  32'(tx_done),  0);
      end else begin
        check("line",  32'(line),     (exp_q.size() == 0) ? 1 : 32'(exp_q[0]));
        check("ready", 32'(tx_ready), 32'(exp_q.size() == 0));
        check("busy",  32'(tx_busy),  32'(exp_q.size() != 0));
        check("done",  32'(tx_done),  32'(exp_done));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Sends one word (or uses an already-armed tx_valid) and decodes the frame from the line
  task automatic run_frame(input logic [7:0] d, input logic [7:0] nxt, input bit keep,
                           input bit disturb, output logic [7:0] dec,
                           output int unsigned done_at, output bit first_low,
                           output bit stop_hi, output bit par, output bit ready_low);
    bit ok;
    int unsigned b;
    if (!tx_valid) begin
      wait_ready(ok);
      check("ready_before_send", 32'(ok), 1);
      tx_data  = d;
      tx_valid = 1'b1;
    end
    tick();
    first_low = (line == 1'b0) && tx_busy;
    if (keep) tx_data = nxt;
    else tx_valid = 1'b0;
    done_at   = 0;
    ready_low = 1'b1;
    dec       = '0;
    stop_hi   = 1'b0;
    par       = 1'b0;
    for (int unsigned n = 1; n <= F1 + 40; n++) begin
      if (n > 1) tick();
      if (tx_done) begin
        done_at = n;
        break;
      end
      if (tx_ready) ready_low = 1'b0;
      if ((n - 1) % BDIV == BDIV / 2) begin
        b = (n - 1) / BDIV;
        if (b >= 1 && b <= DW) dec[b-1] = line;
        else if (P == 1 && b == DW + 1) par = line;
        else if (b == DW + P + 1) stop_hi = line;
      end
      if (disturb && n > 4 && n + 24 < F1) begin
        tx_valid = (n % 2 == 1);
        tx_data  = 8'hFF;
      end else if (disturb && !keep) begin
        tx_valid = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  nxt;
    bit          keep;
    bit          disturb;
    logic [7:0]  exp_dec;
    bit          exp_par_even;
    int unsigned exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  dec;
    int unsigned done_at;
    bit          first_low, stop_hi, par, ready_low, ok;
    int unsigned bad;
    int unsigned last_low;
    int unsigned done2_at;

    vecs[0] = '{8'h55, 8'h00, 1'b0, 1'b0, 8'h55, 1'b0, F1 + 1};
    vecs[1] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0, F1 + 1};
    vecs[2] = '{8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, F1 + 1};
    vecs[3] = '{8'hC3, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, F1 + 1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, F1 + 1};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, F1 + 1};
    vecs[6] = '{8'h07, 8'h00, 1'b0, 1'b0, 8'h07, 1'b1, F1 + 1};
    vecs[7] = '{8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, F1 + 1};

    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_data2  = 8'h00;
    tx_valid2 = 1'b0;
    rst_n     = 1'b1;
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b1;

    // Reset, then a long idle stretch
    repeat (3) tick();
    check("reset_line",  32'(line),     1);
    check("reset_ready", 32'(tx_ready), 1);
    check("reset_busy",  32'(tx_busy),  0);
    check("reset_done",  32'(tx_done),  0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (line !== 1'b1) bad++;
    end
    check("idle_line_high", bad, 0);

    // Table-driven frames: decode, completion latency, start-right-after-done, handshake
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].nxt, vecs[i].keep, vecs[i].disturb,
                dec, done_at, first_low, stop_hi, par, ready_low);
      check($sformatf("vec%0d_decode", i),    32'(dec),       32'(vecs[i].exp_dec));
      check($sformatf("vec%0d_done_at", i),   done_at,        vecs[i].exp_done);
      check($sformatf("vec%0d_start_low", i), 32'(first_low), 1);
      check($sformatf("vec%0d_stop_high", i), 32'(stop_hi),   1);
      check($sformatf("vec%0d_ready_low", i), 32'(ready_low), 1);
`ifdef UART_PARITY_EN
      check($sformatf("vec%0d_parity", i), 32'(par), 32'(vecs[i].exp_par_even ^ (PODD != 0)));
`endif
    end

    // Reset in the middle of data bit 3 of 0xF0, then a clean frame
    wait_ready(ok);
    check("f0_ready", 32'(ok), 1);
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (72) tick();
    check("f0_bit3_low", 32'(line), 0);
    rst_n = 1'b0;
    #1;
    check("midreset_line",  32'(line),     1);
    check("midreset_busy",  32'(tx_busy),  0);
    check("midreset_ready", 32'(tx_ready), 1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_frame(8'h81, 8'h00, 1'b0, 1'b0, dec, done_at, first_low, stop_hi, par, ready_low);
    check("after_reset_decode",  32'(dec), 32'h81);
    check("after_reset_done_at", done_at,  F1 + 1);

    // Two stop bits on the second instance
    check("dut2_ready", 32'(tx_ready2), 1);
    tx_data2  = 8'h00;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    last_low  = 0;
    done2_at  = 0;
    for (int unsigned n = 1; n <= F2 + 40; n++) begin
      if (n > 1) tick();
      if (tx_done2) begin
        done2_at = n;
        break;
      end
      if (line2 == 1'b0) last_low = n;
    end
    check("dut2_done_at",  done2_at,                F2 + 1);
    check("dut2_stop_len", done2_at - 1 - last_low, 2 * BDIV);
    check("dut2_idle_line", 32'(line2), 1);

    // Random traffic against the queue model
    repeat (3000) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    repeat (F1 + 5) tick();
    check("drain_idle", 32'(tx_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
